// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch next-PC/redirect/stall sequencer (optional FETCH_CTRL_PERF_EN perf counters)

`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

package fetch_redirect_pkg;
   typedef enum logic [1:0] {
      pc_plus_4_t = 2'd0,
      sb_t        = 2'd1,
      uj_t        = 2'd2,
      jalr_t      = 2'd3
   } next_pc_t;
endpackage

module fetch_redirect_ctrl
   import fetch_redirect_pkg::*;
#(
   parameter int FETCH_WIDTH     = `FETCH_WIDTH,
   parameter int INST_ADDR_WIDTH = `INST_ADDR_WIDTH,
   parameter int FQ_DEPTH        = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       br_valid,
   output logic                       br_ready,
   input  next_pc_t                   br_sel,
   input  logic [INST_ADDR_WIDTH-1:0] br_target,
   input  logic                       ext_stall,
   input  logic                       end_of_code,
   input  logic                       fq_release,
   output next_pc_t                   next_pc_sel,
   output logic [INST_ADDR_WIDTH-1:0] redirect_addr,
   output logic                       fetch_stall,
   output logic                       fq_flush,
   output logic                       fetch_fire
`ifdef FETCH_CTRL_PERF_EN
   ,
   output logic [31:0]                perf_stall_cycles,
   output logic [31:0]                perf_redirects
`endif
);

   localparam int CW = $clog2(FQ_DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(FQ_DEPTH);

   generate
      if (FQ_DEPTH < 1 || FETCH_WIDTH < 1) begin : g_param_check
         $error("fetch_redirect_ctrl: FQ_DEPTH and FETCH_WIDTH must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, REDIR, HALT} state_t;

   state_t                     state;
   logic [CW-1:0]              credits;
   logic                       pend_valid;
   next_pc_t                   pend_sel;
   logic [INST_ADDR_WIDTH-1:0] pend_addr;

   logic          handshake;
   logic          redir_issue;
   logic          release_ok;
   logic [CW-1:0] credits_next;
   // High when the queue returns a credit it never took; visible to simulation checkers.
   logic          release_overflow;

   assign br_ready         = ~pend_valid;
   assign redirect_addr    = pend_addr;
   assign handshake        = br_valid & ~pend_valid & (state != IDLE);
   assign redir_issue      = (state == REDIR) & ~ext_stall;
   assign release_ok       = fq_release & (credits != FULL);
   assign release_overflow = fq_release & (credits == FULL) & ~redir_issue;

   // Fetch-unit controls decoded from the current state and live backend/end-of-code inputs.
   always_comb begin
      next_pc_sel = pc_plus_4_t;
      fetch_stall = 1'b1;
      fq_flush    = 1'b0;
      fetch_fire  = 1'b0;
      unique case (state)
         IDLE: fetch_stall = 1'b1;
         RUN: begin
            fetch_stall = ext_stall | (credits == '0);
            fetch_fire  = ~(ext_stall | (credits == '0)) & ~end_of_code;
         end
         REDIR: begin
            next_pc_sel = pend_sel;
            fetch_stall = ext_stall;
            fq_flush    = ~ext_stall;
         end
         HALT: fetch_stall = 1'b1;
      endcase
   end

   // Credit bookkeeping: refill on redirect issue, otherwise +release -fire with saturation at full.
   always_comb begin
      credits_next = credits;
      if (redir_issue) begin
         credits_next = FULL;
      end else begin
         unique case ({release_ok, fetch_fire})
            2'b10:   credits_next = credits + 1'b1;
            2'b01:   credits_next = credits - 1'b1;
            default: credits_next = credits;
         endcase
      end
   end

   // Sequencer state, credit counter and the single-entry pending redirect holder.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         credits    <= FULL;
         pend_valid <= 1'b0;
         pend_sel   <= pc_plus_4_t;
         pend_addr  <= '0;
      end else begin
         credits <= credits_next;
         if (redir_issue) begin
            state      <= RUN;
            pend_valid <= 1'b0;
         end else if (handshake) begin
            state      <= REDIR;
            pend_valid <= 1'b1;
            pend_sel   <= br_sel;
            pend_addr  <= br_target;
         end else begin
            unique case (state)
               IDLE:    state <= RUN;
               RUN:     state <= end_of_code ? HALT : RUN;
               default: state <= state;
            endcase
         end
      end
   end

`ifdef FETCH_CTRL_PERF_EN
   // Free-running perf counters: stalled fetch cycles while active, and issued redirects.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stall_cycles <= '0;
         perf_redirects    <= '0;
      end else begin
         if ((state == RUN || state == REDIR) && fetch_stall)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (redir_issue)
            perf_redirects <= perf_redirects + 32'd1;
      end
   end
`endif

endmodule
